// File: rtl/hlu.sv
// rtl/hlu.sv - HI/LO multiply-divide unit; optional flush port under HLU_CANCEL_EN
module hlu (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  hluControl,
   input  logic        hluUnsigned,
   input  logic        hluWrite,
   input  logic        hluDst,
`ifdef HLU_CANCEL_EN
   input  logic        cancel,
`endif
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        start,
   output logic        busy,
   output logic [31:0] hlu_out
);

   localparam logic [3:0] CTRL_MULT = 4'b0001;
   localparam logic [3:0] CTRL_DIV  = 4'b0010;

   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        div_q, div_d;
   logic        uns_q, uns_d;
   logic        busy_q, busy_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        flush;

`ifdef HLU_CANCEL_EN
   assign flush = cancel;
`else
   assign flush = 1'b0;
`endif

   // A flush with nothing in flight still blocks new work in that cycle
   assign start   = ((hluControl == CTRL_MULT) || (hluControl == CTRL_DIV)) && !busy_q && !flush;
   assign busy    = busy_q;
   assign hlu_out = hluDst ? hi_q : lo_q;

   // Product: operands widened to 64 bits (sign or zero) so one multiplier serves both flavours
   logic [63:0] ext_a, ext_b, prod;
   assign ext_a = {{32{a_q[31] & ~uns_q}}, a_q};
   assign ext_b = {{32{b_q[31] & ~uns_q}}, b_q};
   assign prod  = ext_a * ext_b;

   // Division on magnitudes, signs restored afterwards (quotient truncates toward zero)
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
   assign a_neg  = a_q[31] & ~uns_q;
   assign b_neg  = b_q[31] & ~uns_q;
   assign a_mag  = a_neg ? (32'd0 - a_q) : a_q;
   assign b_mag  = b_neg ? (32'd0 - b_q) : b_q;
   assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign q_mag  = a_mag / b_safe;
   assign r_mag  = a_mag % b_safe;
   assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
   assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

   // Next state: count down an in-flight op, else accept a start, else accept mthi/mtlo
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      a_d    = a_q;
      b_d    = b_q;
      div_d  = div_q;
      uns_d  = uns_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (busy_q) begin
         if (flush) begin
            busy_d = 1'b0;
            cnt_d  = 4'd0;
         end else if (cnt_q == 4'd0) begin
            busy_d = 1'b0;
            if (!div_q) begin
               hi_d = prod[63:32];
               lo_d = prod[31:0];
            end else if (b_q != 32'd0) begin
               hi_d = rem;
               lo_d = quo;
            end
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end else if (start) begin
         a_d    = A;
         b_d    = B;
         div_d  = (hluControl == CTRL_DIV);
         uns_d  = hluUnsigned;
         busy_d = 1'b1;
         cnt_d  = (hluControl == CTRL_DIV) ? 4'd9 : 4'd4;
      end else if (hluWrite && !flush) begin
         if (hluDst) hi_d = A;
         else        lo_d = A;
      end
   end

   // State registers, cleared asynchronously so reset abandons any operation
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         div_q  <= 1'b0;
         uns_q  <= 1'b0;
         busy_q <= 1'b0;
         cnt_q  <= 4'd0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         a_q    <= a_d;
         b_q    <= b_d;
         div_q  <= div_d;
         uns_q  <= uns_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hlu.sv
// tb/tb_hlu.sv - self-checking bench for hlu
module tb_hlu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  hluControl;
   logic        hluUnsigned;
   logic        hluWrite;
   logic        hluDst;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic        busy;
   logic [31:0] hlu_out;
`ifdef HLU_CANCEL_EN
   logic        cancel;
`endif

   hlu dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .hluControl  (hluControl),
      .hluUnsigned (hluUnsigned),
      .hluWrite    (hluWrite),
      .hluDst      (hluDst),
`ifdef HLU_CANCEL_EN
      .cancel      (cancel),
`endif
      .A           (A),
      .B           (B),
      .start       (start),
      .busy        (busy),
      .hlu_out     (hlu_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]  ctrl;
      logic        uns;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      hluDst = 1'b1; #1; hi = hlu_out;
      hluDst = 1'b0; #1; lo = hlu_out;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic move_to(input logic dst, input logic [31:0] val);
      @(negedge clk);
      hluWrite = 1'b1; hluDst = dst; A = val;
      @(posedge clk); #1;
      hluWrite = 1'b0;
   endtask

   task automatic run_op(input vec_t v, input string name);
      exp_t e;
      logic [31:0] hi, lo;
      int n;
      @(negedge clk);
      hluControl = v.ctrl; hluUnsigned = v.uns; A = v.a; B = v.b;
      #1;
      chk({name, " start"}, {31'd0, start}, 32'd1);
      sb.push_back('{hi: v.hi, lo: v.lo, cyc: v.cyc});
      @(posedge clk); #1;
      hluControl = 4'd0;
      wait_idle(n);
      e = sb.pop_front();
      read_hilo(hi, lo);
      chk({name, " busy cycles"}, n, e.cyc);
      chk({name, " HI"}, hi, e.hi);
      chk({name, " LO"}, lo, e.lo);
   endtask

   initial begin
      logic [31:0] hi, lo;
      int n;

      vecs[0]  = '{4'd1, 1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1]  = '{4'd1, 1'b1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2]  = '{4'd2, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{4'd2, 1'b1, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[4]  = '{4'd2, 1'b1, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
      vecs[5]  = '{4'd2, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vecs[6]  = '{4'd2, 1'b0, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[7]  = '{4'd1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
      vecs[8]  = '{4'd1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      vecs[9]  = '{4'd1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      vecs[10] = '{4'd2, 1'b0, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 10};

      reset_n = 1'b0; hluControl = 4'd1; hluUnsigned = 1'b0; hluWrite = 1'b0;
      hluDst = 1'b0; A = 32'd0; B = 32'd0;
`ifdef HLU_CANCEL_EN
      cancel = 1'b0;
`endif
      #2;
      chk("reset start follows inputs", {31'd0, start}, 32'd1);
      chk("reset busy", {31'd0, busy}, 32'd0);
      read_hilo(hi, lo);
      chk("reset HI", hi, 32'd0);
      chk("reset LO", lo, 32'd0);
      hluControl = 4'd0;
      @(negedge clk); reset_n = 1'b1;

      // mthi when idle, visible next cycle
      move_to(1'b1, 32'h12345678);
      chk("mthi busy", {31'd0, busy}, 32'd0);
      read_hilo(hi, lo);
      chk("mthi HI", hi, 32'h12345678);

      foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

      // mtlo issued while busy is dropped (divide by zero keeps LO)
      move_to(1'b0, 32'hAAAA0000);
      @(negedge clk);
      hluControl = 4'd2; hluUnsigned = 1'b1; A = 32'd7; B = 32'd0;
      @(posedge clk); #1;
      hluControl = 4'd0;
      @(negedge clk);
      hluWrite = 1'b1; hluDst = 1'b0; A = 32'h55555555;
      @(posedge clk); #1;
      hluWrite = 1'b0;
      wait_idle(n);
      read_hilo(hi, lo);
      chk("mtlo during busy LO", lo, 32'hAAAA0000);

      // mult requested during a div: stalled, then accepted when busy falls
      @(negedge clk);
      hluControl = 4'd2; hluUnsigned = 1'b0; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      @(posedge clk); #1;
      hluControl = 4'd1; A = 32'd3; B = 32'd5;
      #1;
      chk("mult during div start", {31'd0, start}, 32'd0);
      wait_idle(n);
      chk("div before mult busy cycles", n + 1, 10);
      chk("mult accepted when idle", {31'd0, start}, 32'd1);
      read_hilo(hi, lo);
      chk("div intact HI", hi, 32'd2);
      chk("div intact LO", lo, 32'd14);
      @(posedge clk); #1;
      hluControl = 4'd0;
      chk("mult busy after div", {31'd0, busy}, 32'd1);
      wait_idle(n);
      read_hilo(hi, lo);
      chk("back-to-back mult HI", hi, 32'd0);
      chk("back-to-back mult LO", lo, 32'd15);

`ifdef HLU_CANCEL_EN
      // flush mid-div keeps pre-operation HI/LO
      move_to(1'b1, 32'd5);
      move_to(1'b0, 32'd9);
      @(negedge clk);
      hluControl = 4'd2; hluUnsigned = 1'b0; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      hluControl = 4'd0;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk); cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      chk("cancel busy", {31'd0, busy}, 32'd0);
      read_hilo(hi, lo);
      chk("cancel HI", hi, 32'd5);
      chk("cancel LO", lo, 32'd9);
      repeat (12) @(posedge clk);
      #1;
      read_hilo(hi, lo);
      chk("cancel later HI", hi, 32'd5);
      chk("cancel later LO", lo, 32'd9);
      // flush while idle blocks start and move
      @(negedge clk);
      cancel = 1'b1; hluControl = 4'd1; hluWrite = 1'b1; hluDst = 1'b0; A = 32'd77;
      #1;
      chk("idle cancel start", {31'd0, start}, 32'd0);
      @(posedge clk); #1;
      cancel = 1'b0; hluControl = 4'd0; hluWrite = 1'b0;
      chk("idle cancel busy", {31'd0, busy}, 32'd0);
      read_hilo(hi, lo);
      chk("idle cancel LO", lo, 32'd9);
`endif

      // async reset mid-mult
      @(negedge clk);
      hluControl = 4'd1; hluUnsigned = 1'b0; A = 32'd6; B = 32'd7;
      @(posedge clk); #1;
      hluControl = 4'd0;
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      chk("async reset busy", {31'd0, busy}, 32'd0);
      read_hilo(hi, lo);
      chk("async reset HI", hi, 32'd0);
      chk("async reset LO", lo, 32'd0);
      @(negedge clk); reset_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("after reset busy", {31'd0, busy}, 32'd0);
      read_hilo(hi, lo);
      chk("after reset HI", hi, 32'd0);
      chk("after reset LO", lo, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
